// File: rtl/warp_scheduler.sv
// Multi-warp kernel scheduler: round-robin warp select, single-outstanding fetch, issue to lanes.
// Optional WARP_SCHED_MASK_SKIP_EN: zero-mask launches complete immediately and are never scheduled.
module warp_scheduler #(
  parameter int NUM_WARPS  = 4,
  parameter int NUM_LANES  = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch_valid,
  output logic                  launch_ready,
  input  logic [WID_W-1:0]      launch_warp,
  input  logic [ADDR_WIDTH-1:0] launch_addr,
  input  logic [LEN_WIDTH-1:0]  launch_length,
  input  logic [NUM_LANES-1:0]  launch_mask,
  output logic                  fetch_req_valid,
  input  logic                  fetch_req_ready,
  output logic [ADDR_WIDTH-1:0] fetch_req_addr,
  input  logic                  fetch_resp_valid,
  input  logic [31:0]           fetch_resp_data,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [WID_W-1:0]      issue_warp,
  output logic [NUM_LANES-1:0]  issue_mask,
  output logic [NUM_WARPS-1:0]  warp_busy,
  output logic                  done_valid,
  output logic [WID_W-1:0]      done_warp,
  output logic                  error
);

  // state   | meaning
  // S_SEL   | scan for the next busy warp after rr_ptr
  // S_FETCH | request instruction at pc[cur_warp]
  // S_WAIT  | wait for fetch response
  // S_ISSUE | present instruction to the lane array
  localparam logic [1:0] S_SEL   = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ISSUE = 2'd3;

  logic [1:0]            state;
  logic [WID_W-1:0]      cur_warp;
  logic [WID_W-1:0]      rr_ptr;
  logic [WID_W-1:0]      sel_warp;
  logic [WID_W-1:0]      cand;
  logic                  sel_found;
  logic [NUM_WARPS-1:0]  eligible;
  logic [ADDR_WIDTH-1:0] pc   [NUM_WARPS];
  logic [LEN_WIDTH-1:0]  rem  [NUM_WARPS];
  logic [NUM_LANES-1:0]  mask [NUM_WARPS];
  logic [31:0]           instr_q;
  logic                  pend_valid;
  logic [WID_W-1:0]      pend_warp;

  logic launch_fire, launch_misaligned, launch_zero, launch_start, zero_done;
  logic issue_fire, issue_last;

  assign launch_ready      = !warp_busy[launch_warp];
  assign launch_fire       = launch_valid && launch_ready;
  assign launch_misaligned = launch_addr[1:0] != 2'b00;
`ifdef WARP_SCHED_MASK_SKIP_EN
  assign launch_zero = (launch_length == '0) || (launch_mask == '0);
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_WARPS; i++) eligible[i] = warp_busy[i] && (mask[i] != '0);
  end
`else
  assign launch_zero = launch_length == '0;
  assign eligible    = warp_busy;
`endif
  assign zero_done    = launch_fire && !launch_misaligned && launch_zero;
  assign launch_start = launch_fire && !launch_misaligned && !launch_zero;

  assign issue_fire = (state == S_ISSUE) && issue_ready;
  assign issue_last = issue_fire && (rem[cur_warp] == LEN_WIDTH'(1));

  // Offset NUM_WARPS wraps back to rr_ptr itself, so the last warp issued is considered last.
  always_comb begin
    sel_found = 1'b0;
    sel_warp  = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = rr_ptr + WID_W'(i);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_warp  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_SEL;
      cur_warp <= '0;
      rr_ptr   <= WID_W'(NUM_WARPS - 1);
      instr_q  <= '0;
    end else begin
      case (state)
        S_SEL: if (sel_found) begin
          cur_warp <= sel_warp;
          state    <= S_FETCH;
        end
        S_FETCH: if (fetch_req_ready) state <= S_WAIT;
        S_WAIT: if (fetch_resp_valid) begin
          instr_q <= fetch_resp_data;
          state   <= S_ISSUE;
        end
        S_ISSUE: if (issue_ready) begin
          rr_ptr <= cur_warp;
          state  <= S_SEL;
        end
        default: state <= S_SEL;
      endcase
    end
  end

  // A launch only targets an idle warp, so it never collides with the issuing warp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warp_busy <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc[i]   <= '0;
        rem[i]  <= '0;
        mask[i] <= '0;
      end
    end else begin
      if (launch_start) begin
        warp_busy[launch_warp] <= 1'b1;
        pc[launch_warp]        <= launch_addr;
        rem[launch_warp]       <= launch_length;
        mask[launch_warp]      <= launch_mask;
      end
      if (issue_fire) begin
        pc[cur_warp]  <= pc[cur_warp] + ADDR_WIDTH'(4);
        rem[cur_warp] <= rem[cur_warp] - LEN_WIDTH'(1);
        if (issue_last) warp_busy[cur_warp] <= 1'b0;
      end
    end
  end

  // Kernel completion wins the done port; a colliding zero-length done waits one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_valid <= 1'b0;
      done_warp  <= '0;
      pend_valid <= 1'b0;
      pend_warp  <= '0;
      error      <= 1'b0;
    end else begin
      error      <= launch_fire && launch_misaligned;
      done_valid <= 1'b0;
      if (issue_last) begin
        done_valid <= 1'b1;
        done_warp  <= cur_warp;
        if (zero_done) begin
          pend_valid <= 1'b1;
          pend_warp  <= launch_warp;
        end
      end else if (pend_valid) begin
        done_valid <= 1'b1;
        done_warp  <= pend_warp;
        pend_valid <= zero_done;
        if (zero_done) pend_warp <= launch_warp;
      end else if (zero_done) begin
        done_valid <= 1'b1;
        done_warp  <= launch_warp;
      end
    end
  end

  assign fetch_req_valid = state == S_FETCH;
  assign fetch_req_addr  = fetch_req_valid ? pc[cur_warp] : '0;
  assign issue_valid     = state == S_ISSUE;
  assign issue_instr     = issue_valid ? instr_q : '0;
  assign issue_warp      = issue_valid ? cur_warp : '0;
  assign issue_mask      = issue_valid ? mask[cur_warp] : '0;

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: transaction-level model of warp contexts plus directed scenarios.
module tb_warp_scheduler;
  localparam int NW = 4;
  localparam int WW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        launch_valid = 1'b0;
  logic        launch_ready;
  logic [1:0]  launch_warp = '0;
  logic [31:0] launch_addr = '0;
  logic [15:0] launch_length = '0;
  logic [7:0]  launch_mask = '0;
  logic        fetch_req_valid;
  logic        fetch_req_ready = 1'b1;
  logic [31:0] fetch_req_addr;
  logic        fetch_resp_valid = 1'b0;
  logic [31:0] fetch_resp_data = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b1;
  logic [31:0] issue_instr;
  logic [1:0]  issue_warp;
  logic [7:0]  issue_mask;
  logic [3:0]  warp_busy;
  logic        done_valid;
  logic [1:0]  done_warp;
  logic        error;

  warp_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_warp(launch_warp),
    .launch_addr(launch_addr), .launch_length(launch_length), .launch_mask(launch_mask),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready), .fetch_req_addr(fetch_req_addr),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_warp(issue_warp), .issue_mask(issue_mask), .warp_busy(warp_busy),
    .done_valid(done_valid), .done_warp(done_warp), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Model: per-warp contexts, round-robin pointer, issue phase, done arbitration.
  logic [NW-1:0] m_busy;
  logic [31:0]   m_pc [NW];
  int            m_rem [NW];
  logic [7:0]    m_mask [NW];
  int            m_last, m_cur, m_phase, m_dw;
  logic          m_err, m_dv;
  int            zq[$];

  logic [31:0] fetch_log[$];
  int          iss_warp_log[$];
  logic [7:0]  iss_mask_log[$];
  int          iss_cyc_log[$];
  int          done_warp_log[$];
  int          done_cyc_log[$];

  int   c_p;
  logic c_zl, c_comp, c_nerr;

  function automatic int pick();
    for (int k = 1; k <= NW; k++) begin
      int w;
      w = (m_last + k) % NW;
`ifdef WARP_SCHED_MASK_SKIP_EN
      if (m_busy[w] && m_mask[w] != 8'h00) return w;
`else
      if (m_busy[w]) return w;
`endif
    end
    return -1;
  endfunction

  function automatic logic zero_launch(input logic [15:0] len, input logic [7:0] m);
`ifdef WARP_SCHED_MASK_SKIP_EN
    return (len == 16'd0) || (m == 8'h00);
`else
    return (len == 16'd0) && (m == m);
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = '0; m_last = NW - 1; m_phase = 0; m_cur = 0;
      m_err = 1'b0; m_dv = 1'b0; m_dw = 0;
      zq.delete();
      for (int k = 0; k < NW; k++) begin
        m_pc[k] = '0; m_rem[k] = 0; m_mask[k] = '0;
      end
    end else begin
      cyc++;
      chk("error", error, m_err);
      chk("done_valid", done_valid, m_dv);
      if (m_dv) chk("done_warp", done_warp, m_dw);
      if (done_valid) begin
        done_warp_log.push_back(int'(done_warp));
        done_cyc_log.push_back(cyc);
      end
      chk("warp_busy", warp_busy, m_busy);
      if (launch_valid) chk("launch_ready", launch_ready, !m_busy[launch_warp]);
      if (fetch_req_valid) begin
        if (m_phase == 0) begin
          c_p = pick();
          checks++;
          if (c_p < 0) begin
            errors++;
            $display("FAIL fetch_pick: fetch addr %0h with no busy warp, required no fetch", fetch_req_addr);
          end else begin
            m_cur = c_p; m_phase = 1;
            fetch_log.push_back(fetch_req_addr);
          end
        end
        chk("fetch_phase", m_phase, 1);
        chk("fetch_addr", fetch_req_addr, m_pc[m_cur]);
      end
      if (issue_valid) begin
        chk("issue_phase", m_phase, 2);
        chk("issue_warp", issue_warp, m_cur);
        chk("issue_mask", issue_mask, m_mask[m_cur]);
        chk("issue_instr", issue_instr, memfn(m_pc[m_cur]));
      end
      c_zl = 1'b0; c_comp = 1'b0; c_nerr = 1'b0;
      if (launch_valid && !m_busy[launch_warp]) begin
        if (launch_addr[1:0] != 2'b00) c_nerr = 1'b1;
        else if (zero_launch(launch_length, launch_mask)) c_zl = 1'b1;
        else begin
          m_busy[launch_warp] = 1'b1;
          m_pc[launch_warp]   = launch_addr;
          m_rem[launch_warp]  = int'(launch_length);
          m_mask[launch_warp] = launch_mask;
        end
      end
      if (fetch_req_valid && fetch_req_ready && m_phase == 1) m_phase = 2;
      if (issue_valid && issue_ready) begin
        iss_warp_log.push_back(int'(issue_warp));
        iss_mask_log.push_back(issue_mask);
        iss_cyc_log.push_back(cyc);
        m_pc[m_cur]  = m_pc[m_cur] + 32'd4;
        m_rem[m_cur] = m_rem[m_cur] - 1;
        m_last  = m_cur;
        m_phase = 0;
        if (m_rem[m_cur] == 0) begin
          m_busy[m_cur] = 1'b0;
          c_comp = 1'b1;
        end
      end
      m_err = c_nerr;
      m_dv  = 1'b0;
      if (c_comp) begin
        m_dv = 1'b1; m_dw = m_cur;
        if (c_zl) zq.push_back(int'(launch_warp));
      end else if (zq.size() > 0) begin
        m_dv = 1'b1; m_dw = zq.pop_front();
        if (c_zl) zq.push_back(int'(launch_warp));
      end else if (c_zl) begin
        m_dv = 1'b1; m_dw = int'(launch_warp);
      end
    end
  end

  // Memory / lane-array responder with programmable stalls.
  int          fr_stall = 0;
  int          ir_stall = 0;
  logic        resp_hold = 1'b0;
  logic        resp_inject = 1'b0;
  logic        r_hs;
  logic [31:0] r_addr;

  always @(posedge clk) begin
    r_hs   = rst_n && fetch_req_valid && fetch_req_ready;
    r_addr = fetch_req_addr;
    if (fetch_req_valid && fr_stall > 0) fr_stall--;
    if (issue_valid && ir_stall > 0) ir_stall--;
    #1;
    fetch_resp_valid = (r_hs && !resp_hold) || resp_inject;
    fetch_resp_data  = resp_inject ? 32'hDEAD_BEEF : (r_hs ? memfn(r_addr) : 32'h0);
    fetch_req_ready  = (fr_stall == 0);
    issue_ready      = (ir_stall == 0);
  end

  task automatic launch(input int w, input logic [31:0] a, input int len, input logic [7:0] m);
    int   b;
    logic ok;
    b = 0; ok = 1'b0;
    @(posedge clk); #1;
    launch_valid = 1'b1; launch_warp = WW'(w); launch_addr = a;
    launch_length = 16'(len); launch_mask = m;
    while (!ok && b < 50) begin
      @(negedge clk); ok = launch_ready;
      @(posedge clk); #1;
      b++;
    end
    launch_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL launch_timeout: warp %0d never ready, required ready", w);
    end
  endtask

  task automatic wait_idle(input int budget);
    int quiet;
    int b;
    quiet = 0; b = 0;
    while (quiet < 3 && b < budget) begin
      @(negedge clk);
      b++;
      if (warp_busy == '0 && !fetch_req_valid && !issue_valid && !done_valid && m_busy == '0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0h after %0d cycles, required 0", warp_busy, budget);
    end
  endtask

  int fi, ii, di, fcnt, icnt, probe;
  logic dseen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", warp_busy, 0);
    chk("rst_fetch_valid", fetch_req_valid, 0);
    chk("rst_fetch_addr", fetch_req_addr, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_error", error, 0);

    // single warp, three instructions
    fi = fetch_log.size(); ii = iss_warp_log.size(); di = done_warp_log.size();
    launch(0, 32'h1000, 3, 8'hFF);
    wait_idle(80);
    chk("t1_fetch_cnt", fetch_log.size() - fi, 3);
    chk("t1_fetch0", fetch_log[fi], 32'h1000);
    chk("t1_fetch1", fetch_log[fi+1], 32'h1004);
    chk("t1_fetch2", fetch_log[fi+2], 32'h1008);
    for (int k = 0; k < 3; k++) begin
      chk("t1_issue_warp", iss_warp_log[ii+k], 0);
      chk("t1_issue_mask", iss_mask_log[ii+k], 8'hFF);
    end
    chk("t1_done_warp", done_warp_log[di], 0);
    chk("t1_done_lat", done_cyc_log[di], iss_cyc_log[ii+2] + 1);

    // two warps interleaved round-robin
    fi = fetch_log.size(); ii = iss_warp_log.size(); di = done_warp_log.size();
    launch(1, 32'h2000, 2, 8'h0F);
    launch(3, 32'h3000, 2, 8'hF0);
    wait_idle(100);
    chk("t2_order0", iss_warp_log[ii], 1);
    chk("t2_order1", iss_warp_log[ii+1], 3);
    chk("t2_order2", iss_warp_log[ii+2], 1);
    chk("t2_order3", iss_warp_log[ii+3], 3);
    chk("t2_fetch2", fetch_log[fi+2], 32'h2004);
    chk("t2_fetch3", fetch_log[fi+3], 32'h3004);
    chk("t2_done0", done_warp_log[di], 1);
    chk("t2_done1", done_warp_log[di+1], 3);
    chk("t2_busy_end", warp_busy, 0);

    // misaligned launch and zero-length launch
    fi = fetch_log.size();
    launch(0, 32'h1002, 5, 8'hFF);
    @(negedge clk);
    chk("t3_error_pulse", error, 1);
    chk("t3_busy", warp_busy, 0);
    @(negedge clk);
    chk("t3_error_clear", error, 0);
    launch(2, 32'h2200, 0, 8'hFF);
    @(negedge clk);
    chk("t3_zero_done", done_valid, 1);
    chk("t3_zero_warp", done_warp, 2);
    wait_idle(40);
    chk("t3_no_fetch", fetch_log.size() - fi, 0);

    // stalled fetch and issue; probe launch into the busy warp
    fr_stall = 3; ir_stall = 5;
    launch(2, 32'h4000, 1, 8'h5A);
    fcnt = 0; icnt = 0; probe = 0; dseen = 1'b0;
    for (int c = 0; c < 40 && !dseen; c++) begin
      @(negedge clk);
      if (fetch_req_valid) begin
        fcnt++;
        chk("t4_fetch_addr", fetch_req_addr, 32'h4000);
      end
      if (issue_valid) begin
        icnt++;
        chk("t4_issue_instr", issue_instr, 32'hC0DE_4000);
        chk("t4_issue_warp", issue_warp, 2);
        chk("t4_issue_mask", issue_mask, 8'h5A);
      end
      if (probe == 1) begin
        chk("t4_busy_launch_ready", launch_ready, 0);
        probe = 2;
      end
      if (done_valid) begin
        dseen = 1'b1;
        chk("t4_done_warp", done_warp, 2);
      end
      @(posedge clk); #1;
      if (probe == 0 && icnt == 1) begin
        launch_valid = 1'b1; launch_warp = 2'd2; launch_addr = 32'h5000;
        launch_length = 16'd1; launch_mask = 8'hFF;
        probe = 1;
      end else if (probe == 2) begin
        launch_valid = 1'b0;
        probe = 3;
      end
    end
    launch_valid = 1'b0;
    chk("t4_fetch_cycles", fcnt, 4);
    chk("t4_issue_cycles", icnt, 6);
    chk("t4_done_seen", dseen, 1);
    wait_idle(40);

    // zero lane mask
    fi = fetch_log.size(); ii = iss_warp_log.size(); di = done_warp_log.size();
    launch(1, 32'h6000, 4, 8'h00);
    @(negedge clk);
`ifdef WARP_SCHED_MASK_SKIP_EN
    chk("t5_done_next", done_valid, 1);
    chk("t5_done_warp", done_warp, 1);
    wait_idle(40);
    chk("t5_no_fetch", fetch_log.size() - fi, 0);
    chk("t5_no_issue", iss_warp_log.size() - ii, 0);
`else
    chk("t5_no_early_done", done_valid, 0);
    wait_idle(100);
    chk("t5_issue_cnt", iss_warp_log.size() - ii, 4);
    for (int k = 0; k < 4; k++) chk("t5_issue_mask", iss_mask_log[ii+k], 8'h00);
    chk("t5_fetch3", fetch_log[fi+3], 32'h600C);
    chk("t5_done_warp", done_warp_log[di], 1);
`endif

    // reset while waiting for the fetch response
    ii = iss_warp_log.size();
    resp_hold = 1'b1;
    launch(0, 32'h7000, 2, 8'hFF);
    begin
      int b;
      b = 0;
      while (b < 20 && !(fetch_req_valid && fetch_req_ready)) begin
        @(negedge clk); b++;
      end
      if (b >= 20) begin
        checks++; errors++;
        $display("FAIL t6_fetch_timeout: no fetch handshake, required one");
      end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1; resp_hold = 1'b0;
    @(negedge clk); resp_inject = 1'b1;
    @(negedge clk); resp_inject = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("t6_issue_valid", issue_valid, 0);
      chk("t6_fetch_valid", fetch_req_valid, 0);
      chk("t6_busy", warp_busy, 0);
      chk("t6_issue_instr", issue_instr, 0);
      chk("t6_done", done_valid, 0);
    end
    chk("t6_no_issue", iss_warp_log.size() - ii, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Multi-warp successor to the single-warp kernel controller.
- Holds NUM_WARPS independent kernel contexts (PC, remaining count, lane mask).
- Selects one active warp round-robin, fetches its next 32-bit instruction over a single-outstanding fetch port, and issues it with warp ID and mask to the lane array.
- Sits between the RoCC command decoder (launches) and memory/lane array (fetch/issue).

Parameters:
NUM_WARPS, 4, number of warp contexts (power of two, >=2)
NUM_LANES, 8, lanes per warp; width of masks
ADDR_WIDTH, 32, instruction address width
LEN_WIDTH, 16, kernel length width (in instructions)
WID_W, $clog2(NUM_WARPS), warp ID width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset
launch_valid  in  1  launch request
launch_ready  out  1  = !warp_busy[launch_warp]
launch_warp  in  WID_W  target context
launch_addr  in  ADDR_WIDTH  kernel start PC
launch_length  in  LEN_WIDTH  instruction count
launch_mask  in  NUM_LANES  lane enable mask
fetch_req_valid  out  1  fetch request
fetch_req_ready  in  1  memory accepts
fetch_req_addr  out  ADDR_WIDTH  fetch PC
fetch_resp_valid  in  1  fetched word valid (always accepted)
fetch_resp_data  in  32  fetched instruction
issue_valid  out  1  instruction to lanes
issue_ready  in  1  lane array accepts
issue_instr  out  32  instruction
issue_warp  out  WID_W  issuing warp
issue_mask  out  NUM_LANES  mask of issuing warp
warp_busy  out  NUM_WARPS  per-context active flag
done_valid  out  1  one-cycle completion pulse
done_warp  out  WID_W  completed warp
error  out  1  one-cycle pulse: misaligned launch

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, all contexts idle, rr_ptr=NUM_WARPS-1, FSM=S_SEL.
- Launch handshake:
  - Accepted when launch_valid && launch_ready.
  - launch_addr[1:0]!=0: accepted, error pulses next cycle, context stays idle, no done.
  - length==0: accepted, done_valid/done_warp pulse next cycle, context stays idle.
  - Otherwise: warp_busy bit set next cycle; pc=addr, rem=length, mask latched.
- FSM S_SEL:
  - Pick the first busy warp scanning rr_ptr+1 upward, wrapping modulo NUM_WARPS.
  - None busy: stay in S_SEL. Else latch cur_warp, go to S_FETCH.
- FSM S_FETCH: fetch_req_valid=1, fetch_req_addr=pc[cur]. On fetch_req_ready go to S_WAIT. Address held stable while stalled.
- FSM S_WAIT: on fetch_resp_valid, register the data into issue_instr and go to S_ISSUE.
- FSM S_ISSUE:
  - issue_valid=1; instr/warp/mask held stable until issue_ready.
  - On handshake: pc+=4 (wraps at ADDR_WIDTH); rem-=1; rr_ptr=cur_warp; go to S_SEL.
  - If rem was 1: busy bit cleared and done pulse on the following cycle.
- Minimum per-instruction latency: S_SEL -> S_ISSUE handshake, 4 cycles with ready/resp immediate.
- Launch and completion of the same warp in the same cycle: launch_ready is still 0 (busy). The launch is accepted next cycle.
- Launch into warp X while another warp is mid-fetch is legal and does not disturb the in-flight instruction.
- Completion done pulse takes priority over a zero-length-launch done in the same cycle. The zero-length done is delayed one cycle (a 1-entry pending register).
- Asynchronous reset mid-fetch: all state cleared. Any later fetch_resp_valid with FSM not in S_WAIT is ignored.

Optional Feature:
- Macro: WARP_SCHED_MASK_SKIP_EN.
- Defined:
  - A launch with launch_mask==0 and a valid, nonzero-length request never becomes busy.
  - It produces a done pulse next cycle, with no fetches or issues.
  - S_SEL also skips busy warps whose mask is 0 (defensive).
- Undefined: zero-mask warps fetch and issue normally with issue_mask=0, then complete.

Test Plan:
- Launch warp0 addr 0x1000 len 3 mask 0xFF, ready/resp immediate -> fetch addrs 0x1000/0x1004/0x1008, three issues warp0 mask 0xFF, done_warp=0 one cycle after third issue.
- Launch warp1 (0x2000,len 2) and warp3 (0x3000,len 2) back-to-back -> issue order w1,w3,w1,w3; two done pulses (w1 then w3); warp_busy returns to 0.
- Launch addr 0x1002 -> error pulse 1 cycle, warp_busy unchanged, no fetch; launch len 0 to warp2 -> done_warp=2 pulse, no fetch.
- Hold issue_ready=0 for 5 cycles and fetch_req_ready=0 for 3 cycles -> issue_instr/warp/mask and fetch_req_addr stable; second launch to the busy warp sees launch_ready=0.
- Assert rst_n=0 while in S_WAIT, then deliver fetch_resp_valid after release -> all outputs 0, no issue.
- Launch mask 0x00 len 4 -> with WARP_SCHED_MASK_SKIP_EN: done next cycle, zero fetches; without: 4 issues with issue_mask=0 then done.
